apb_chip_ctrl_demux: RTL and testbench
======================================

// Module: apb_chip_ctrl_demux
// PURPOSE
//  Registered APB demultiplexer for the chip-control region exported by the SoC domain. One upstream
//  APB slave port fans out to NUM_PORTS downstream APB masters (pad mux, clock gen, FLL, user regs)
//  by mask/base decode. Adds a per-transfer timeout and error responses for unmapped or hung accesses.
//  Sits between the SoC domain's chip-ctrl APB port and the platform-specific control blocks.
// PARAMETERS
//  NUM_PORTS      4                  number of downstream APB ports (1..16)
//  ADDR_WIDTH     32                 APB address width
//  DATA_WIDTH     32                 APB data width; pstrb is DATA_WIDTH/8
//  PORT_BASE      '0                 packed [NUM_PORTS*ADDR_WIDTH] base address per port
//  PORT_MASK      '0                 packed [NUM_PORTS*ADDR_WIDTH] match mask per port
//  TIMEOUT_CYCLES 256                access-phase wait limit; 0 disables timeout
//  ERR_DATA       32'hBADACCE5       prdata returned on decode miss or timeout
// PORTS
//  soc_clk_i        in   1               clock
//  soc_rst_synced_i in   1               synchronous reset, active-high
//  s_paddr_i        in   ADDR_WIDTH      upstream address
//  s_pprot_i        in   3               upstream protection
//  s_psel_i         in   1               upstream select
//  s_penable_i      in   1               upstream enable
//  s_pwrite_i       in   1               upstream write
//  s_pwdata_i       in   DATA_WIDTH      upstream write data
//  s_pstrb_i        in   DATA_WIDTH/8    upstream byte strobes
//  s_prdata_o       out  DATA_WIDTH      upstream read data
//  s_pready_o       out  1               upstream ready
//  s_pslverr_o      out  1               upstream error
//  m_paddr_o / m_pprot_o / m_pwrite_o / m_pwdata_o / m_pstrb_o  out  shared   registered request, common to all ports
//  m_psel_o         out  NUM_PORTS       per-port select
//  m_penable_o      out  1               shared enable
//  m_prdata_i       in   NUM_PORTS*DATA_WIDTH  per-port read data
//  m_pready_i       in   NUM_PORTS       per-port ready
//  m_pslverr_i      in   NUM_PORTS       per-port error
//  timeout_o        out  1               one-cycle pulse when a transfer times out
//  err_cnt_o        out  8               saturating count of decode misses + timeouts
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0. Reset mid-transfer drops m_psel_o the next edge; no upstream response.
//  Decode: hit[k] = ((s_paddr_i & MASK[k]) == BASE[k]); lowest k wins on overlap; no hit = miss.
//  FSM IDLE: on s_psel_i=1, latch paddr/pprot/pwrite/pwdata/pstrb and port index.
//    hit -> M_SETUP; miss -> RESP with pslverr=1, prdata=ERR_DATA, err_cnt++.
//  M_SETUP: m_psel_o[k]=1, m_penable_o=0; -> M_ACCESS. Timeout counter cleared.
//  M_ACCESS: m_psel_o[k]=1, m_penable_o=1; only m_pready_i[k]/m_pslverr_i[k]/m_prdata_i[k] observed.
//    pready -> capture prdata (0 on writes), pslverr; -> RESP.
//    else counter++; counter==TIMEOUT_CYCLES-1 without pready -> drop psel, timeout_o=1,
//    pslverr=1, prdata=ERR_DATA, err_cnt++; -> RESP. pready on that same cycle wins over timeout.
//  RESP: s_pready_o=1 one cycle with registered s_prdata_o/s_pslverr_o; -> IDLE. Outside RESP,
//    s_pready_o=0 and s_prdata_o/s_pslverr_o=0.
//  Latency: zero-wait hit: upstream setup at cycle 0 -> s_pready_o at cycle 3; each downstream wait
//    state adds 1. Miss: s_pready_o at cycle 1. Back-to-back upstream setup in cycle after RESP accepted.
//  Upstream must hold request stable until s_pready_o (APB rule); block does not re-sample it.
//  err_cnt_o saturates at 8'hFF; never wraps.
// TESTING
//  Write port 1 (zero-wait), 0xA5A5_0001 strb 4'hF -> m_psel_o=4'b0010 cycles 1-2, s_pready_o cycle 3, pslverr=0.
//  Read port 2 with 3 wait states, prdata 0x1234_5678 -> s_pready_o at cycle 6, s_prdata_o=0x1234_5678.
//  Access unmapped addr -> s_pready_o at cycle 1, pslverr=1, prdata=0xBADACCE5, err_cnt_o=1, no m_psel_o.
//  TIMEOUT_CYCLES=8, port never ready -> timeout_o pulse, pslverr=1, ERR_DATA; pready on cycle 7 instead -> no error.
//  Overlapping map ports 0/3 -> port 0 selected; 300 misses -> err_cnt_o stays 8'hFF.
//  Assert soc_rst_synced_i during M_ACCESS -> all outputs 0 next cycle; next transfer completes normally.

Source files
------------

// File: rtl/apb_chip_ctrl_demux_if.sv
// ---------------------------------------------------------------------------
// apb_chip_ctrl_demux_if
//  Bus bundle for the chip-control APB demultiplexer.
//  Upstream side (s_*): one APB requester entering the demux.
//  Downstream side (m_*): shared request lines, one-hot select and per-port
//  packed response lines (port k occupies slice [k*W +: W]).
//  Modports:
//    slave  - the demux itself (accepts upstream, drives downstream)
//    master - the environment around it (drives upstream, answers downstream)
// ---------------------------------------------------------------------------
interface apb_chip_ctrl_demux_if #(
   parameter int NUM_PORTS  = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   // upstream
   logic [ADDR_WIDTH-1:0]           s_paddr_i;
   logic [2:0]                      s_pprot_i;
   logic                            s_psel_i;
   logic                            s_penable_i;
   logic                            s_pwrite_i;
   logic [DATA_WIDTH-1:0]           s_pwdata_i;
   logic [DATA_WIDTH/8-1:0]         s_pstrb_i;
   logic [DATA_WIDTH-1:0]           s_prdata_o;
   logic                            s_pready_o;
   logic                            s_pslverr_o;
   // downstream
   logic [ADDR_WIDTH-1:0]           m_paddr_o;
   logic [2:0]                      m_pprot_o;
   logic                            m_pwrite_o;
   logic [DATA_WIDTH-1:0]           m_pwdata_o;
   logic [DATA_WIDTH/8-1:0]         m_pstrb_o;
   logic [NUM_PORTS-1:0]            m_psel_o;
   logic                            m_penable_o;
   logic [NUM_PORTS*DATA_WIDTH-1:0] m_prdata_i;
   logic [NUM_PORTS-1:0]            m_pready_i;
   logic [NUM_PORTS-1:0]            m_pslverr_i;

   modport slave (
      input  s_paddr_i, s_pprot_i, s_psel_i, s_penable_i, s_pwrite_i, s_pwdata_i, s_pstrb_i,
      output s_prdata_o, s_pready_o, s_pslverr_o,
      output m_paddr_o, m_pprot_o, m_pwrite_o, m_pwdata_o, m_pstrb_o, m_psel_o, m_penable_o,
      input  m_prdata_i, m_pready_i, m_pslverr_i
   );

   modport master (
      output s_paddr_i, s_pprot_i, s_psel_i, s_penable_i, s_pwrite_i, s_pwdata_i, s_pstrb_i,
      input  s_prdata_o, s_pready_o, s_pslverr_o,
      input  m_paddr_o, m_pprot_o, m_pwrite_o, m_pwdata_o, m_pstrb_o, m_psel_o, m_penable_o,
      output m_prdata_i, m_pready_i, m_pslverr_i
   );
endinterface

// File: rtl/apb_chip_ctrl_demux.sv
// ---------------------------------------------------------------------------
// apb_chip_ctrl_demux
//  Registered APB demultiplexer for the chip-control region. One upstream APB
//  requester is decoded by mask/base into NUM_PORTS downstream APB ports.
//  Unmapped accesses and downstream accesses that wait too long are answered
//  locally with pslverr=1 and ERR_DATA, and counted in a saturating counter.
//  Ports:
//    soc_clk_i        clock
//    soc_rst_synced_i synchronous reset, active-high
//    bus              apb_chip_ctrl_demux_if.slave (upstream + downstream APB)
//    timeout_o        one-cycle pulse (in the response cycle) on a timeout
//    err_cnt_o        saturating count of decode misses + timeouts
// ---------------------------------------------------------------------------
module apb_chip_ctrl_demux #(
   parameter int                            NUM_PORTS      = 4,
   parameter int                            ADDR_WIDTH     = 32,
   parameter int                            DATA_WIDTH     = 32,
   parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] PORT_BASE    = '0,
   parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] PORT_MASK    = '0,
   parameter int                            TIMEOUT_CYCLES = 256,
   parameter logic [DATA_WIDTH-1:0]         ERR_DATA       = 32'hBADACCE5
) (
   input  logic                 soc_clk_i,
   input  logic                 soc_rst_synced_i,
   apb_chip_ctrl_demux_if.slave bus,
   output logic                 timeout_o,
   output logic [7:0]           err_cnt_o
);
   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, M_SETUP, M_ACCESS, RESP} state_t;

   state_t                state_reg,   state_next;
   logic [ADDR_WIDTH-1:0] paddr_reg,   paddr_next;
   logic [2:0]            pprot_reg,   pprot_next;
   logic                  pwrite_reg,  pwrite_next;
   logic [DATA_WIDTH-1:0] pwdata_reg,  pwdata_next;
   logic [STRB_W-1:0]     pstrb_reg,   pstrb_next;
   logic [IDX_W-1:0]      port_reg,    port_next;
   logic [DATA_WIDTH-1:0] prdata_reg,  prdata_next;
   logic                  pslverr_reg, pslverr_next;
   logic [TO_W-1:0]       to_cnt_reg,  to_cnt_next;
   logic                  timeout_reg, timeout_next;
   logic [7:0]            err_cnt_reg, err_cnt_next;
   logic                  err_inc;

   // ---------------- address decode (lowest index wins) ----------------
   logic [NUM_PORTS-1:0]  hit;
   logic                  dec_hit;
   logic [IDX_W-1:0]      dec_idx;
   logic [DATA_WIDTH-1:0] prdata_arr [NUM_PORTS];

   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign hit[gi] = ((bus.s_paddr_i & PORT_MASK[gi*ADDR_WIDTH +: ADDR_WIDTH])
                        == PORT_BASE[gi*ADDR_WIDTH +: ADDR_WIDTH]);
      assign prdata_arr[gi] = bus.m_prdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
      // select is a pure function of registered state, so it is glitch-free
      assign bus.m_psel_o[gi] = ((state_reg == M_SETUP) || (state_reg == M_ACCESS))
                                && (port_reg == IDX_W'(gi));
   end

   always_comb begin
      dec_hit = |hit;
      dec_idx = '0;
      // scan downward so the lowest matching index is the last one written
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         if (hit[k]) dec_idx = IDX_W'(k);
      end
   end

   // only the selected port's response is ever looked at
   logic                  sel_pready;
   logic                  sel_pslverr;
   logic [DATA_WIDTH-1:0] sel_prdata;
   assign sel_pready  = bus.m_pready_i[port_reg];
   assign sel_pslverr = bus.m_pslverr_i[port_reg];
   assign sel_prdata  = prdata_arr[port_reg];

   // ---------------- next-state / datapath ----------------
   always_comb begin
      state_next   = state_reg;
      paddr_next   = paddr_reg;
      pprot_next   = pprot_reg;
      pwrite_next  = pwrite_reg;
      pwdata_next  = pwdata_reg;
      pstrb_next   = pstrb_reg;
      port_next    = port_reg;
      prdata_next  = prdata_reg;
      pslverr_next = pslverr_reg;
      to_cnt_next  = to_cnt_reg;
      timeout_next = 1'b0;
      err_inc      = 1'b0;

      case (state_reg)
         IDLE: begin
            if (bus.s_psel_i) begin
               paddr_next  = bus.s_paddr_i;
               pprot_next  = bus.s_pprot_i;
               pwrite_next = bus.s_pwrite_i;
               pwdata_next = bus.s_pwdata_i;
               pstrb_next  = bus.s_pstrb_i;
               port_next   = dec_idx;
               if (dec_hit) begin
                  state_next = M_SETUP;
               end else begin
                  state_next   = RESP;
                  prdata_next  = ERR_DATA;
                  pslverr_next = 1'b1;
                  err_inc      = 1'b1;
               end
            end
         end
         M_SETUP: begin
            to_cnt_next = '0;
            state_next  = M_ACCESS;
         end
         M_ACCESS: begin
            // a ready on the last allowed cycle still completes normally
            if (sel_pready) begin
               prdata_next  = pwrite_reg ? '0 : sel_prdata;
               pslverr_next = sel_pslverr;
               state_next   = RESP;
            end else if ((TIMEOUT_CYCLES != 0) && (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1))) begin
               prdata_next  = ERR_DATA;
               pslverr_next = 1'b1;
               timeout_next = 1'b1;
               err_inc      = 1'b1;
               state_next   = RESP;
            end else begin
               to_cnt_next = to_cnt_reg + TO_W'(1);
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      err_cnt_next = (err_inc && (err_cnt_reg != 8'hFF)) ? err_cnt_reg + 8'd1 : err_cnt_reg;
   end

   always_ff @(posedge soc_clk_i) begin
      if (soc_rst_synced_i) begin
         state_reg   <= IDLE;
         paddr_reg   <= '0;
         pprot_reg   <= '0;
         pwrite_reg  <= 1'b0;
         pwdata_reg  <= '0;
         pstrb_reg   <= '0;
         port_reg    <= '0;
         prdata_reg  <= '0;
         pslverr_reg <= 1'b0;
         to_cnt_reg  <= '0;
         timeout_reg <= 1'b0;
         err_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         paddr_reg   <= paddr_next;
         pprot_reg   <= pprot_next;
         pwrite_reg  <= pwrite_next;
         pwdata_reg  <= pwdata_next;
         pstrb_reg   <= pstrb_next;
         port_reg    <= port_next;
         prdata_reg  <= prdata_next;
         pslverr_reg <= pslverr_next;
         to_cnt_reg  <= to_cnt_next;
         timeout_reg <= timeout_next;
         err_cnt_reg <= err_cnt_next;
      end
   end

   // ---------------- outputs ----------------
   assign bus.m_paddr_o   = paddr_reg;
   assign bus.m_pprot_o   = pprot_reg;
   assign bus.m_pwrite_o  = pwrite_reg;
   assign bus.m_pwdata_o  = pwdata_reg;
   assign bus.m_pstrb_o   = pstrb_reg;
   assign bus.m_penable_o = (state_reg == M_ACCESS);

   assign bus.s_pready_o  = (state_reg == RESP);
   assign bus.s_prdata_o  = (state_reg == RESP) ? prdata_reg : '0;
   assign bus.s_pslverr_o = (state_reg == RESP) ? pslverr_reg : 1'b0;

   assign timeout_o = timeout_reg;
   assign err_cnt_o = err_cnt_reg;
endmodule

// File: tb/tb_apb_chip_ctrl_demux.sv
module tb_apb_chip_ctrl_demux;
   localparam int NP = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int T  = 8;
   localparam logic [31:0] ERR = 32'hBADACCE5;
   // port 3 overlaps port 0 (and 1, 2); lower index must win
   localparam logic [NP*AW-1:0] BASES = {32'h1000_0000, 32'h1002_0000, 32'h1001_0000, 32'h1000_0000};
   localparam logic [NP*AW-1:0] MASKS = {32'hFF00_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000};

   // address map as the bench sees it
   logic [31:0] map_base [NP] = '{32'h1000_0000, 32'h1001_0000, 32'h1002_0000, 32'h1000_0000};
   logic [31:0] map_mask [NP] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFF00_0000};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic timeout;
   logic [7:0] err_cnt;
   always #5 clk = ~clk;

   apb_chip_ctrl_demux_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   apb_chip_ctrl_demux #(
      .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .PORT_BASE(BASES), .PORT_MASK(MASKS),
      .TIMEOUT_CYCLES(T), .ERR_DATA(ERR)
   ) dut (
      .soc_clk_i(clk),
      .soc_rst_synced_i(rst),
      .bus(bus.slave),
      .timeout_o(timeout),
      .err_cnt_o(err_cnt)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // per-cycle expectations, written by the stimulus process
   bit          chk_en = 0;
   logic        e_act, e_pen, e_rdy, e_err, e_to, e_wr;
   logic [3:0]  e_psel, e_strb;
   logic [2:0]  e_prot;
   logic [31:0] e_data, e_addr, e_wdata;
   logic [7:0]  e_cnt;
   int          m_err_cnt = 0;

   // observations of the running transfer, for the hand-computed checks
   int          cyc = 0;
   int          obs_resp_cyc;
   logic [31:0] obs_data;
   logic        obs_err, obs_to;
   logic [7:0]  obs_cnt;
   logic [3:0]  obs_psel;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_psel", 32'(bus.m_psel_o), 32'(e_psel));
         chk("m_penable", 32'(bus.m_penable_o), 32'(e_pen));
         chk("s_pready", 32'(bus.s_pready_o), 32'(e_rdy));
         chk("s_prdata", bus.s_prdata_o, e_data);
         chk("s_pslverr", 32'(bus.s_pslverr_o), 32'(e_err));
         chk("timeout", 32'(timeout), 32'(e_to));
         chk("err_cnt", 32'(err_cnt), 32'(e_cnt));
         if (e_act) begin
            chk("m_paddr", bus.m_paddr_o, e_addr);
            chk("m_pwrite", 32'(bus.m_pwrite_o), 32'(e_wr));
            chk("m_pwdata", bus.m_pwdata_o, e_wdata);
            chk("m_pstrb", 32'(bus.m_pstrb_o), 32'(e_strb));
            chk("m_pprot", 32'(bus.m_pprot_o), 32'(e_prot));
         end
         if (bus.s_pready_o) begin
            obs_resp_cyc = cyc;
            obs_data     = bus.s_prdata_o;
            obs_err      = bus.s_pslverr_o;
            obs_to       = timeout;
            obs_cnt      = err_cnt;
         end
         obs_psel = obs_psel | bus.m_psel_o;
      end
   end

   task automatic set_idle_exp();
      e_act = 0; e_pen = 0; e_rdy = 0; e_err = 0; e_to = 0;
      e_psel = '0; e_data = '0; e_cnt = 8'(m_err_cnt);
   endtask

   // random responses on every downstream port
   task automatic noise();
      for (int k = 0; k < NP; k++) bus.m_prdata_i[k*DW +: DW] = $urandom;
      bus.m_pready_i  = 4'($urandom);
      bus.m_pslverr_i = 4'($urandom);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         bus.s_psel_i = 0; bus.s_penable_i = 0;
         noise();
         set_idle_exp();
         @(posedge clk); #1;
      end
   endtask

   // One upstream transfer; w = downstream wait states (w >= T: never ready).
   task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [2:0] prot, input int w,
                       input logic [31:0] rdata, input logic slverr);
      int port = -1;
      int resp;
      logic timed_out = 0;
      logic [31:0] r_data;
      logic r_err;
      for (int k = 0; k < NP; k++)
         if (port < 0 && (addr & map_mask[k]) == map_base[k]) port = k;
      if (port < 0) begin
         resp = 1; r_data = ERR; r_err = 1;
      end else if (w >= T) begin
         resp = 2 + T; r_data = ERR; r_err = 1; timed_out = 1;
      end else begin
         resp = 3 + w; r_data = wr ? 32'h0 : rdata; r_err = slverr;
      end
      obs_resp_cyc = -1; obs_psel = '0; obs_data = '0; obs_err = 0; obs_to = 0; obs_cnt = '0;
      for (int c = 0; c <= resp; c++) begin
         cyc = c;
         bus.s_psel_i = 1; bus.s_penable_i = (c >= 1);
         bus.s_paddr_i = addr; bus.s_pwrite_i = wr; bus.s_pwdata_i = wdata;
         bus.s_pstrb_i = strb; bus.s_pprot_i = prot;
         noise();
         if (port >= 0) begin
            bus.m_pready_i[port] = (w < T) && (c == 2 + w);
            if (bus.m_pready_i[port]) begin
               bus.m_prdata_i[port*DW +: DW] = rdata;
               bus.m_pslverr_i[port] = slverr;
            end
         end
         set_idle_exp();
         if (port >= 0 && c >= 1 && c < resp) begin
            e_act = 1; e_psel = 4'(1 << port); e_pen = (c >= 2);
            e_addr = addr; e_wr = wr; e_wdata = wdata; e_strb = strb; e_prot = prot;
         end
         if (c == resp) begin
            if (port < 0 || timed_out) m_err_cnt = (m_err_cnt < 255) ? m_err_cnt + 1 : 255;
            e_rdy = 1; e_data = r_data; e_err = r_err; e_to = timed_out;
            e_cnt = 8'(m_err_cnt);
         end
         @(posedge clk); #1;
      end
      bus.s_psel_i = 0; bus.s_penable_i = 0;
      set_idle_exp();
      cyc = -1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      int sel;
      bus.s_paddr_i = '0; bus.s_pprot_i = '0; bus.s_psel_i = 0; bus.s_penable_i = 0;
      bus.s_pwrite_i = 0; bus.s_pwdata_i = '0; bus.s_pstrb_i = '0;
      bus.m_prdata_i = '0; bus.m_pready_i = '0; bus.m_pslverr_i = '0;
      rst = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pready", 32'(bus.s_pready_o), 0);
      chk("rst_prdata", bus.s_prdata_o, 0);
      chk("rst_psel", 32'(bus.m_psel_o), 0);
      chk("rst_penable", 32'(bus.m_penable_o), 0);
      chk("rst_err_cnt", 32'(err_cnt), 0);
      chk("rst_timeout", 32'(timeout), 0);
      rst = 0;
      set_idle_exp();
      chk_en = 1;
      idle(2);

      // zero-wait write to port 1
      xfer(32'h1001_0004, 1, 32'hA5A5_0001, 4'hF, 3'd0, 0, 32'h0, 0);
      $display("write port1: resp_cyc=%0d psel=%b err=%0d", obs_resp_cyc, obs_psel, obs_err);
      chk("wr_latency", 32'(obs_resp_cyc), 3);
      chk("wr_psel", 32'(obs_psel), 32'b0010);
      chk("wr_slverr", 32'(obs_err), 0);

      // read port 2 with 3 wait states
      xfer(32'h1002_0008, 0, 32'h0, 4'h0, 3'd2, 3, 32'h1234_5678, 0);
      $display("read port2: resp_cyc=%0d data=%h", obs_resp_cyc, obs_data);
      chk("rd_latency", 32'(obs_resp_cyc), 6);
      chk("rd_data", obs_data, 32'h1234_5678);

      // unmapped
      xfer(32'h2000_0000, 0, 32'h0, 4'h0, 3'd0, 0, 32'h0, 0);
      $display("miss: resp_cyc=%0d data=%h err=%0d cnt=%0d", obs_resp_cyc, obs_data, obs_err, obs_cnt);
      chk("miss_latency", 32'(obs_resp_cyc), 1);
      chk("miss_data", obs_data, 32'hBADACCE5);
      chk("miss_slverr", 32'(obs_err), 1);
      chk("miss_err_cnt", 32'(obs_cnt), 1);
      chk("miss_psel", 32'(obs_psel), 0);

      // port 3 never ready -> timeout
      xfer(32'h1005_0000, 0, 32'h0, 4'h0, 3'd1, 99, 32'h0, 0);
      $display("timeout: resp_cyc=%0d to=%0d err=%0d data=%h", obs_resp_cyc, obs_to, obs_err, obs_data);
      chk("to_pulse", 32'(obs_to), 1);
      chk("to_slverr", 32'(obs_err), 1);
      chk("to_data", obs_data, 32'hBADACCE5);
      chk("to_latency", 32'(obs_resp_cyc), 10);

      // ready on the last allowed access cycle wins over timeout
      xfer(32'h1001_0010, 0, 32'h0, 4'h0, 3'd0, 7, 32'hCAFE_0007, 0);
      $display("late ready: resp_cyc=%0d to=%0d err=%0d data=%h", obs_resp_cyc, obs_to, obs_err, obs_data);
      chk("late_to", 32'(obs_to), 0);
      chk("late_slverr", 32'(obs_err), 0);
      chk("late_data", obs_data, 32'hCAFE_0007);

      // overlap of ports 0 and 3
      xfer(32'h1000_0010, 0, 32'h0, 4'h0, 3'd0, 0, 32'h0000_00AA, 1);
      $display("overlap: psel=%b err=%0d", obs_psel, obs_err);
      chk("overlap_psel", 32'(obs_psel), 32'b0001);
      chk("overlap_slverr", 32'(obs_err), 1);

      // randomized traffic
      for (int i = 0; i < 150; i++) begin
         sel = $urandom_range(0, 4);
         a = $urandom;
         case (sel)
            0: a = {16'h1000, a[15:0]};
            1: a = {16'h1001, a[15:0]};
            2: a = {16'h1002, a[15:0]};
            3: a = {8'h10, 8'($urandom_range(3, 255)), a[15:0]};
            default: a = {8'($urandom_range(17, 255)), a[23:0]};
         endcase
         xfer(a, 1'($urandom), $urandom, 4'($urandom), 3'($urandom), $urandom_range(0, 9),
              $urandom, 1'($urandom));
         $display("rand %0d: addr=%h resp_cyc=%0d data=%h err=%0d to=%0d", i, a, obs_resp_cyc,
                  obs_data, obs_err, obs_to);
         if ($urandom_range(0, 3) == 0) idle(1);
      end

      // reset in the middle of an access phase
      chk_en = 0;
      bus.s_psel_i = 1; bus.s_penable_i = 0; bus.s_paddr_i = 32'h1002_0010; bus.s_pwrite_i = 0;
      noise(); bus.m_pready_i[2] = 0;
      @(posedge clk); #1;
      bus.s_penable_i = 1; noise(); bus.m_pready_i[2] = 0;
      @(posedge clk); #1;
      noise(); bus.m_pready_i[2] = 0;
      chk("pre_rst_psel", 32'(bus.m_psel_o), 32'b0100);
      chk("pre_rst_penable", 32'(bus.m_penable_o), 1);
      rst = 1;
      @(posedge clk); #1;
      $display("mid-access reset: psel=%b penable=%0d cnt=%0d", bus.m_psel_o, bus.m_penable_o, err_cnt);
      chk("mrst_psel", 32'(bus.m_psel_o), 0);
      chk("mrst_penable", 32'(bus.m_penable_o), 0);
      chk("mrst_pready", 32'(bus.s_pready_o), 0);
      chk("mrst_paddr", bus.m_paddr_o, 0);
      chk("mrst_err_cnt", 32'(err_cnt), 0);
      rst = 0;
      m_err_cnt = 0;
      set_idle_exp();
      chk_en = 1;
      idle(2);
      xfer(32'h1001_0020, 0, 32'h0, 4'h0, 3'd0, 1, 32'h0BAD_F00D, 0);
      $display("after reset: resp_cyc=%0d data=%h", obs_resp_cyc, obs_data);
      chk("post_rst_latency", 32'(obs_resp_cyc), 4);
      chk("post_rst_data", obs_data, 32'h0BAD_F00D);

      // saturation of the error counter
      for (int i = 0; i < 300; i++)
         xfer({8'($urandom_range(17, 255)), 24'($urandom)}, 0, 32'h0, 4'h0, 3'd0, 0, 32'h0, 0);
      $display("after 300 misses: err_cnt=%0d", err_cnt);
      chk("sat_err_cnt", 32'(err_cnt), 32'hFF);
      idle(2);
      chk_en = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
